// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO controller: register map, TX states, defaults.
package uart_mmio_pkg;

  localparam int RX_DEPTH_DEFAULT = 4;

  localparam logic [1:0] OFF_RX_STAT = 2'd0;
  localparam logic [1:0] OFF_RX_DATA = 2'd1;
  localparam logic [1:0] OFF_TX_STAT = 2'd2;
  localparam logic [1:0] OFF_TX_DATA = 2'd3;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_HOLD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive buffer; head byte is visible combinationally, count is registered.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need one,
  // and leaving data unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART window: decodes E-stage loads/stores, buffers RX bytes, holds one TX byte.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int          RX_DEPTH  = RX_DEPTH_DEFAULT,
  parameter logic [31:0] UART_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] mmio_addr,
  input  logic        mmio_rd,
  input  logic        mmio_wr,
  input  logic [7:0]  mmio_wdata,
  output logic        mmio_sel,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  logic                      hit, accept, rd_acc, wr_acc;
  logic [1:0]                offset;
  logic                      tx_write, ovr_set, ovr_clr;
  logic                      overrun;
  logic                      load_byte;
  tx_state_e                 state_q, state_d;
  logic [31:0]               rdata_d;
  logic [7:0]                rx_head;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                      rx_full, rx_empty;
  logic                      unused_bits;

  assign offset   = mmio_addr[3:2];
  assign hit      = (mmio_addr[31:4] == UART_BASE[31:4]);
  assign accept   = hit && !stall && (mmio_rd || mmio_wr);
  // A combined rd+wr is treated purely as a store.
  assign wr_acc   = accept && mmio_wr;
  assign rd_acc   = accept && mmio_rd && !mmio_wr;
  assign tx_write = wr_acc && (offset == OFF_TX_DATA);
  assign ovr_set  = tx_write && (state_q == TX_HOLD);
  assign ovr_clr  = rd_acc && (offset == OFF_TX_STAT);

  assign unused_bits = ^{mmio_addr[1:0], rx_count};

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (uart_dout_valid),
    .push_data (uart_dout),
    .pop       (rd_acc && (offset == OFF_RX_DATA)),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign uart_dout_ready = !rx_full;
  assign uart_din_valid  = (state_q == TX_HOLD);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    load_byte = 1'b0;
    case (state_q)
      TX_IDLE: if (tx_write) begin
        state_d   = TX_HOLD;
        load_byte = 1'b1;
      end
      TX_HOLD: if (uart_din_ready) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    case (offset)
      OFF_RX_STAT: rdata_d = {31'b0, !rx_empty};
      OFF_RX_DATA: rdata_d = rx_empty ? 32'b0 : {24'b0, rx_head};
      OFF_TX_STAT: rdata_d = {30'b0, overrun, state_q == TX_IDLE};
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      uart_din   <= '0;
      overrun    <= 1'b0;
      mmio_sel   <= 1'b0;
      mmio_rdata <= '0;
    end else begin
      state_q  <= state_d;
      if (load_byte) uart_din <= mmio_wdata;
      // Setting wins over the read-clear so an overrun is never lost.
      overrun  <= ovr_set || (overrun && !ovr_clr);
      mmio_sel <= rd_acc;
      if (rd_acc) mmio_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: scoreboarded MMIO reads, RX byte model, TX handshake checks.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_RX_STAT = BASE + 32'h0;
  localparam logic [31:0] A_RX_DATA = BASE + 32'h4;
  localparam logic [31:0] A_TX_STAT = BASE + 32'h8;
  localparam logic [31:0] A_TX_DATA = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] mmio_addr;
  logic        mmio_rd, mmio_wr;
  logic [7:0]  mmio_wdata;
  logic        mmio_sel;
  logic [31:0] mmio_rdata;
  logic [7:0]  uart_din;
  logic        uart_din_valid;
  logic        uart_din_ready;
  logic [7:0]  uart_dout;
  logic        uart_dout_valid;
  logic        uart_dout_ready;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];
  logic [7:0]  rx_model[$];

  uart_mmio_ctrl #(.RX_DEPTH(4), .UART_BASE(32'h8000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .mmio_addr       (mmio_addr),
    .mmio_rd         (mmio_rd),
    .mmio_wr         (mmio_wr),
    .mmio_wdata      (mmio_wdata),
    .mmio_sel        (mmio_sel),
    .mmio_rdata      (mmio_rdata),
    .uart_din        (uart_din),
    .uart_din_valid  (uart_din_valid),
    .uart_din_ready  (uart_din_ready),
    .uart_dout       (uart_dout),
    .uart_dout_valid (uart_dout_valid),
    .uart_dout_ready (uart_dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load-data monitor: every mmio_sel pulse consumes one scoreboard entry.
  always @(posedge clk) begin
    #2;
    if (mmio_sel) begin
      if (tag_q.size() == 0) check("sel_unexpected", 32'd1, 32'd0);
      else check(tag_q.pop_front(), mmio_rdata, val_q.pop_front());
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic bus(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [7:0] wd, input logic st,
                     input logic expect_sel, input string tag, input logic [31:0] exp);
    mmio_addr = addr; mmio_rd = rd; mmio_wr = wr; mmio_wdata = wd; stall = st;
    if (expect_sel) begin
      tag_q.push_back(tag);
      val_q.push_back(exp);
    end
    @(negedge clk);
    mmio_rd = 1'b0; mmio_wr = 1'b0; stall = 1'b0;
    check({tag, "_pending"}, tag_q.size(), 0);
  endtask

  task automatic rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    bus(addr, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, tag, exp);
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] exp;
    exp = (rx_model.size() != 0) ? {24'b0, rx_model.pop_front()} : 32'd0;
    rd(A_RX_DATA, tag, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] data);
    bus(addr, 1'b0, 1'b1, data, 1'b0, 1'b0, "", 32'd0);
  endtask

  task automatic rx_send(input logic [7:0] b);
    bit done;
    done = 0;
    uart_dout = b;
    uart_dout_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (uart_dout_ready) begin
        rx_model.push_back(b);
        done = 1;
      end
      @(negedge clk);
    end
    uart_dout_valid = 1'b0;
    if (!done) check("rx_send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; mmio_addr = '0; mmio_rd = 1'b0; mmio_wr = 1'b0;
    mmio_wdata = '0; uart_din_ready = 1'b0; uart_dout = '0; uart_dout_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sel", mmio_sel, 0);
    check("rst_rdata", mmio_rdata, 0);
    check("rst_din", uart_din, 0);
    check("rst_din_valid", uart_din_valid, 0);
    reset = 1'b1;
    check("rst_dout_ready", uart_dout_ready, 1);

    // Basic receive and read-back, then empty-read behaviour.
    rx_send(8'h41);
    rx_send(8'h42);
    rd(A_RX_STAT, "rx_stat_full", 32'd1);
    rd_rx("rx_data_41");
    rd_rx("rx_data_42");
    rd(A_RX_STAT, "rx_stat_empty", 32'd0);
    rd_rx("rx_data_empty");

    // Fill to depth, hold off the fifth byte, pop one, then drain across the wrap.
    for (int i = 0; i < 4; i++) rx_send(8'hA0 + 8'(i));
    check("ready_full", uart_dout_ready, 0);
    uart_dout = 8'hA4;
    uart_dout_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_held", uart_dout_ready, 0);
    rd_rx("pop_while_full");
    check("ready_after_pop", uart_dout_ready, 1);
    @(negedge clk);
    rx_model.push_back(8'hA4);
    uart_dout_valid = 1'b0;
    for (int i = 0; i < 4; i++) rd_rx("drain_wrap");
    rd(A_RX_STAT, "rx_stat_drained", 32'd0);

    // Push into an empty FIFO while reading: the new byte is not yet visible.
    uart_dout = 8'h63; uart_dout_valid = 1'b1;
    rd(A_RX_DATA, "push_pop_empty", 32'd0);
    rx_model.push_back(8'h63);
    uart_dout_valid = 1'b0;
    // Push and pop together on a non-empty FIFO: the old head comes out.
    uart_dout = 8'h64; uart_dout_valid = 1'b1;
    rd_rx("push_pop_head");
    rx_model.push_back(8'h64);
    uart_dout_valid = 1'b0;
    rd(A_RX_STAT, "push_pop_stat", 32'd1);
    rd_rx("push_pop_new");

    // Stalled, combined rd+wr, and out-of-window accesses have no effect.
    rx_send(8'h71);
    bus(A_RX_DATA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "stall_rd", 32'd0);
    bus(A_RX_DATA, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, "rdwr", 32'd0);
    bus(BASE + 32'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "miss", 32'd0);
    wr(A_RX_DATA, 8'hEE);
    rd_rx("after_stall_pop");
    rd(A_TX_STAT + 32'd3, "addr_low_ignored", 32'd1);
    rd(A_TX_DATA, "tx_data_read", 32'd0);

    // Transmit with back-pressure: byte held stable until ready.
    wr(A_TX_DATA, 8'h55);
    for (int i = 0; i < 2; i++) begin
      check("tx_valid_hold", uart_din_valid, 1);
      check("tx_din_hold", uart_din, 32'h55);
      @(negedge clk);
    end
    rd(A_TX_STAT, "tx_stat_busy", 32'd0);
    check("tx_din_stable", uart_din, 32'h55);
    uart_din_ready = 1'b1;
    @(negedge clk);
    uart_din_ready = 1'b0;
    check("tx_valid_idle", uart_din_valid, 0);
    rd(A_TX_STAT, "tx_stat_idle", 32'd1);

    // Overrun: second byte dropped, status 2'b10, then clears and shows idle after drain.
    wr(A_TX_DATA, 8'h11);
    wr(A_TX_DATA, 8'h22);
    check("ovr_din_kept", uart_din, 32'h11);
    rd(A_TX_STAT, "ovr_stat", 32'd2);
    uart_din_ready = 1'b1;
    @(negedge clk);
    uart_din_ready = 1'b0;
    rd(A_TX_STAT, "ovr_cleared", 32'd1);

    // Write during the handshake cycle is also an overrun.
    wr(A_TX_DATA, 8'h33);
    uart_din_ready = 1'b1;
    wr(A_TX_DATA, 8'h44);
    uart_din_ready = 1'b0;
    check("hs_ovr_idle", uart_din_valid, 0);
    rd(A_TX_STAT, "hs_ovr_stat", 32'd3);

    // Reset mid-operation with buffered RX bytes and a held TX byte.
    for (int i = 0; i < 3; i++) rx_send(8'hC0 + 8'(i));
    wr(A_TX_DATA, 8'h99);
    rd(A_RX_STAT, "pre_reset_stat", 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_sel", mmio_sel, 0);
    check("mid_rst_rdata", mmio_rdata, 0);
    check("mid_rst_din", uart_din, 0);
    check("mid_rst_din_valid", uart_din_valid, 0);
    rx_model.delete();
    @(negedge clk);
    reset = 1'b1;
    uart_din_ready = 1'b1;
    check("post_rst_ready", uart_dout_ready, 1);
    rd(A_RX_STAT, "post_rst_rx_stat", 32'd0);
    rd(A_TX_STAT, "post_rst_tx_stat", 32'd1);
    check("post_rst_no_tx", uart_din_valid, 0);
    uart_din_ready = 1'b0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 Parameter RX_DEPTH, default 4, RX FIFO entries (power of 2, >=2).
REQ-002 Parameter UART_BASE, default 32'h8000_0000, base of the 16-byte UART register window.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 stall  in  1  pipeline stall; high = MMIO access ignored this cycle.
REQ-006 mmio_addr  in  32  E-stage effective address (ALU output).
REQ-007 mmio_rd  in  1  E-stage load.
REQ-008 mmio_wr  in  1  E-stage store.
REQ-009 mmio_wdata  in  8  E-stage store data, rt[7:0].
REQ-010 mmio_sel  out  1  registered; M-stage writeback selects mmio_rdata.
REQ-011 mmio_rdata  out  32  registered M-stage load data.
REQ-012 uart_din  out  8  byte to UART transmitter.
REQ-013 uart_din_valid  out  1  transmit handshake valid.
REQ-014 uart_din_ready  in  1  transmit handshake ready.
REQ-015 uart_dout  in  8  byte from UART receiver.
REQ-016 uart_dout_valid  in  1  receive handshake valid.
REQ-017 uart_dout_ready  out  1  receive handshake ready.

Function
REQ-018 Hit = mmio_addr[31:4] == UART_BASE[31:4]; mmio_addr[1:0] ignored; offset = mmio_addr[3:2].
REQ-019 Access accepted only when hit && !stall && (mmio_rd || mmio_wr); rd and wr together: wr wins, no read side effect.
REQ-020 Map: offset 0 RX status (bit0 = RX FIFO non-empty); 1 RX data (pop); 2 TX status (bit0 = tx idle, bit1 = overrun sticky); 3 TX data (push). Unused bits read 0.
REQ-021 Load latency 1: accepted read in cycle N -> mmio_sel=1 and mmio_rdata valid in N+1; otherwise mmio_sel=0 and mmio_rdata holds.
REQ-022 RX FIFO: circular buffer, read/write pointers log2(RX_DEPTH) bits, wrap naturally; count log2(RX_DEPTH)+1 bits.
REQ-023 uart_dout_ready = (count < RX_DEPTH), decoded from registered count only.
REQ-024 Push on uart_dout_valid && uart_dout_ready.
REQ-025 Pop on accepted read of offset 1 with count > 0; rdata = {24'b0, head byte}.
REQ-026 Read of offset 1 when empty returns 0, pointers and count unchanged.
REQ-027 Simultaneous push and pop: both occur, count unchanged; popped byte is the old head (a byte pushed into an empty FIFO is not readable that cycle).
REQ-028 TX FSM states TX_IDLE, TX_HOLD; uart_din_valid = (state == TX_HOLD); uart_din = held byte.
REQ-029 TX_IDLE + accepted write offset 3 -> latch mmio_wdata, TX_HOLD next cycle.
REQ-030 TX_HOLD + uart_din_valid && uart_din_ready -> TX_IDLE next cycle; held byte stable while in TX_HOLD.
REQ-031 Write offset 3 in TX_HOLD (including the handshake cycle): byte dropped, overrun sticky set.
REQ-032 Accepted read of offset 2 returns the current overrun value, then clears it; set and clear in the same cycle -> remains set.
REQ-033 Writes to offsets 0, 1, 2 ignored; read of offset 3 returns 0.

Reset
REQ-034 While reset low: mmio_sel=0, mmio_rdata=0, uart_din=0, uart_din_valid=0, FIFO pointers/count=0 (uart_dout_ready=1 after release), TX_IDLE, overrun=0.
REQ-035 Reset mid-operation discards the held TX byte and all FIFO contents without completing any handshake.
REQ-036 First accepted access takes effect on the first rising edge after reset deasserts.

Structure
REQ-037 Package uart_mmio_pkg holds the register offsets, the TX state enum and the default RX_DEPTH; the module's UART_BASE default takes the value 32'h8000_0000.
REQ-038 RX buffer is a sub-module uart_rx_fifo (push/pop, full/empty, count); the remaining logic is in uart_mmio_ctrl.

Verification
REQ-039 Receive bytes 0x41, 0x42 -> RX status reads 1; two reads of offset 1 return 0x41, then 0x42; RX status then reads 0.
REQ-040 Receive 5 bytes with no reads (RX_DEPTH=4) -> uart_dout_ready=0 after the 4th; 5th held off; popping one byte -> ready=1, 5th byte accepted; order preserved, including across pointer wrap.
REQ-041 Store 0x55 to offset 3 with uart_din_ready=0 for 3 cycles -> din_valid=1, din=0x55 stable; TX status bit0=0; ready=1 -> IDLE next cycle.
REQ-042 Store 0x11 then 0x22 while in TX_HOLD -> 0x22 dropped; TX status reads 2'b10, then reads 2'b01 after drain.
REQ-043 Read of offset 1 with stall=1 -> no pop, mmio_sel=0 next cycle; the same read with stall=0 pops.
REQ-044 Assert reset with 3 bytes buffered and TX_HOLD -> all outputs 0 immediately; after release RX status=0, TX status=1.
